// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble packer.
//   NIB_W   : width of one upstream FIFO entry (4 bits)
//   BYTE_W  : width of one packed output byte (8 bits)
//   state_t : packer FSM states
//     S_LO  - awaiting the first nibble of a byte
//     S_HI  - awaiting the second nibble
//     S_OUT - a byte is held with out_valid=1
package nibble_pkg;

    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_LO  = 2'd0,
        S_HI  = 2'd1,
        S_OUT = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_packer.sv
// nibble_packer: pops 4-bit nibbles from a show-ahead FIFO and packs them
// pairwise into bytes presented on a valid/ready output port.
//
// Parameters
//   HI_FIRST : 0 = first nibble lands in out_data[3:0], 1 = in out_data[7:4]
//   CNT_W    : width of byte_count
// Ports
//   clk          : clock, rising edge
//   rstN         : asynchronous active-low reset
//   fifo_empty   : upstream FIFO empty flag
//   fifo_data    : upstream show-ahead data (valid while fifo_empty=0)
//   fifo_rd_en   : pop request; fifo_data is consumed in the same cycle
//   flush        : emit a pending half byte, zero padded
//   out_valid    : byte available on out_data
//   out_ready    : downstream accepts the byte
//   out_data     : packed byte
//   out_parity   : XOR of out_data
//   out_partial  : byte came from a flush (second slot is padding)
//   byte_count   : number of accepted output bytes (wraps)
module nibble_packer
    import nibble_pkg::*;
#(
    parameter bit HI_FIRST = 1'b0,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                fifo_empty,
    input  logic [NIB_W-1:0]    fifo_data,
    output logic                fifo_rd_en,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BYTE_W-1:0]   out_data,
    output logic                out_parity,
    output logic                out_partial,
    output logic [CNT_W-1:0]    byte_count
);

    state_t              state_reg;
    logic [NIB_W-1:0]    first_slot_reg;
    logic                out_valid_reg;
    logic [BYTE_W-1:0]   out_data_reg;
    logic                out_parity_reg;
    logic                out_partial_reg;
    logic [CNT_W-1:0]    byte_count_reg;

    logic                handshake;
    logic [BYTE_W-1:0]   full_byte;
    logic [BYTE_W-1:0]   flush_byte;

    // Popping is also blocked while reset is held so the FIFO never loses a
    // nibble to a packer that is about to discard it.
    assign fifo_rd_en = rstN && !fifo_empty &&
                        ((state_reg == S_LO) || (state_reg == S_HI) ||
                         ((state_reg == S_OUT) && out_ready));

    assign handshake = out_valid_reg && out_ready;

    // The second slot is never stored separately: it goes straight from
    // fifo_data into the registered output byte.
    assign full_byte  = HI_FIRST ? {first_slot_reg, fifo_data}
                                 : {fifo_data, first_slot_reg};
    assign flush_byte = HI_FIRST ? {first_slot_reg, {NIB_W{1'b0}}}
                                 : {{NIB_W{1'b0}}, first_slot_reg};

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_reg       <= S_LO;
            first_slot_reg  <= '0;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
            out_parity_reg  <= 1'b0;
            out_partial_reg <= 1'b0;
            byte_count_reg  <= '0;
        end else begin
            if (handshake) begin
                byte_count_reg <= byte_count_reg + CNT_W'(1);
            end

            case (state_reg)
                S_LO: begin
                    if (fifo_rd_en) begin
                        first_slot_reg <= fifo_data;
                        state_reg      <= S_HI;
                    end
                end

                S_HI: begin
                    // A real nibble always wins over flush.
                    if (fifo_rd_en) begin
                        out_data_reg    <= full_byte;
                        out_parity_reg  <= ^full_byte;
                        out_partial_reg <= 1'b0;
                        out_valid_reg   <= 1'b1;
                        state_reg       <= S_OUT;
                    end else if (flush) begin
                        out_data_reg    <= flush_byte;
                        out_parity_reg  <= ^flush_byte;
                        out_partial_reg <= 1'b1;
                        out_valid_reg   <= 1'b1;
                        state_reg       <= S_OUT;
                    end
                end

                S_OUT: begin
                    if (handshake) begin
                        out_valid_reg <= 1'b0;
                        // Popping during the handshake starts the next byte
                        // without a bubble cycle.
                        if (fifo_rd_en) begin
                            first_slot_reg <= fifo_data;
                            state_reg      <= S_HI;
                        end else begin
                            state_reg <= S_LO;
                        end
                    end
                end

                default: begin
                    out_valid_reg <= 1'b0;
                    state_reg     <= S_LO;
                end
            endcase
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_data    = out_data_reg;
    assign out_parity  = out_parity_reg;
    assign out_partial = out_partial_reg;
    assign byte_count  = byte_count_reg;

endmodule

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 Parameter HI_FIRST, default 0: 0 = first nibble read lands in out_data[3:0]; 1 = first nibble lands in out_data[7:4].
REQ-002 Parameter CNT_W, default 8: width of byte_count.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 rstN  input  1  reset, asynchronous, active-low.
REQ-005 fifo_empty  input  1  upstream 4-bit FIFO empty flag.
REQ-006 fifo_data  input  4  upstream FIFO show-ahead read data, valid combinationally while fifo_empty=0.
REQ-007 fifo_rd_en  output  1  pop request to upstream FIFO; the nibble on fifo_data is consumed in the same cycle.
REQ-008 flush  input  1  emit a pending half byte zero-padded.
REQ-009 out_valid  output  1  byte available on out_data.
REQ-010 out_ready  input  1  downstream accepts byte.
REQ-011 out_data  output  8  packed byte.
REQ-012 out_parity  output  1  even parity, XOR of out_data[7:0].
REQ-013 out_partial  output  1  byte was produced by flush (upper/second slot is zero padding).
REQ-014 byte_count  output  CNT_W  count of accepted output bytes.

Function
REQ-015 FSM states: S_LO (awaiting first nibble), S_HI (awaiting second nibble), S_OUT (byte held, out_valid=1).
REQ-016 fifo_rd_en SHALL be combinational: !fifo_empty AND (state==S_LO OR state==S_HI OR (state==S_OUT AND out_ready)); never asserted while fifo_empty=1.
REQ-017 S_LO: on fifo_rd_en, capture fifo_data into the first slot, go to S_HI; otherwise stay.
REQ-018 S_HI: on fifo_rd_en, capture fifo_data into the second slot, register out_data/out_parity, clear out_partial, go to S_OUT.
REQ-019 S_HI with fifo_empty=1 and flush=1: out_data = first nibble with second slot 4'h0, out_partial=1, go to S_OUT; if fifo_empty=0 the normal read takes priority and flush is ignored.
REQ-020 flush in S_LO or S_OUT SHALL have no effect.
REQ-021 S_OUT: out_valid=1 and out_data/out_parity/out_partial stable until out_valid AND out_ready.
REQ-022 S_OUT handshake with fifo_rd_en=1: nibble captured into the first slot, go to S_HI (no bubble); handshake without read: go to S_LO.
REQ-023 out_valid SHALL be a registered decode of state==S_OUT; latency from second nibble pop to out_valid is 1 cycle.
REQ-024 byte_count SHALL increment by 1 on every out_valid AND out_ready cycle, wrapping from 2^CNT_W-1 to 0.
REQ-025 Sustained throughput SHALL be one byte per 2 cycles when FIFO non-empty and out_ready=1.
REQ-026 No nibble SHALL be dropped or duplicated; out_ready low SHALL stall popping exactly as REQ-016 defines.

Reset
REQ-027 rstN low SHALL immediately force state=S_LO, out_valid=0, out_data=8'h00, out_parity=0, out_partial=0, byte_count=0, slot registers=0.
REQ-028 Reset mid-byte SHALL discard any captured nibble; first pop after release starts a new byte.
REQ-029 Release of rstN is synchronous-deasserted externally; the block SHALL not pop in the cycle rstN is low.

Structure
REQ-030 Package nibble_pkg SHALL hold NIB_W=4, BYTE_W=8 and the state enum typedef (S_LO, S_HI, S_OUT).
REQ-031 Single flat module; no sub-module; parity computed inline.

Verification
REQ-032 HI_FIRST=0, FIFO holds 4'hA,4'h5, out_ready=1 -> one byte 8'h5A, out_parity=0, out_partial=0, byte_count=1.
REQ-033 HI_FIRST=1, same stimulus -> out_data=8'hA5; FIFO holds 8 nibbles continuously -> 4 bytes, out_valid every other cycle, no gaps.
REQ-034 out_ready held low 5 cycles in S_OUT with FIFO non-empty -> out_data stable, fifo_rd_en=0 for all 5 cycles, no nibble lost.
REQ-035 Single nibble 4'h7 then FIFO empty, flush pulse -> out_data=8'h07, out_partial=1, out_parity=1; flush in S_LO -> no output.
REQ-036 rstN asserted in S_HI after nibble 4'h3 -> all outputs zero immediately; then nibbles 4'h1,4'h2 -> byte 8'h21.
REQ-037 CNT_W=2, five accepted bytes -> byte_count sequence 1,2,3,0,1.
